// File: rtl/clkgate_ctrl.sv
// Enable-side controller for one gated clock domain.
// Drops E after an idle interval and re-enables it on demand with a Req/Ack handshake.
module clkgate_ctrl #(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic Busy,
  input  logic Req,
  input  logic Disable,
  output logic E,
  output logic Ack,
  output logic Gated
);

  localparam int MAXC = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYCLES - 1);
  localparam logic [CW-1:0] WAKE_LAST = CW'(WAKE_CYCLES - 1);

  typedef enum logic [1:0] {
    ON,
    DRAIN,
    OFF,
    WAKE
  } state_t;

  state_t state;
  state_t state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic e_nxt;
  logic ack_nxt;
  logic gated_nxt;
  logic active;

  assign active = Busy | Req | Disable;

  // Next state, counter, and the registered output values for that state.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      ON: begin
        cnt_nxt = '0;
        if (!active) begin
          if (IDLE_CYCLES == 1) begin
            state_nxt = OFF;
          end else begin
            state_nxt = DRAIN;
            cnt_nxt   = CW'(1);
          end
        end
      end
      DRAIN: begin
        if (active) begin
          state_nxt = ON;
          cnt_nxt   = '0;
        end else if (cnt == IDLE_LAST) begin
          state_nxt = OFF;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      OFF: begin
        cnt_nxt = '0;
        if (active) begin
          state_nxt = WAKE;
        end
      end
      WAKE: begin
        if (cnt == WAKE_LAST) begin
          state_nxt = ON;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = ON;
        cnt_nxt   = '0;
      end
    endcase
    // Outputs decoded from the next state so they land in flops (glitch-free E).
    e_nxt     = (state_nxt != OFF);
    ack_nxt   = (state_nxt == ON) || (state_nxt == DRAIN);
    gated_nxt = (state_nxt == OFF);
  end

  // State, counter and output registers; reset leaves the clock running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ON;
      cnt   <= '0;
      E     <= 1'b1;
      Ack   <= 1'b1;
      Gated <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      E     <= e_nxt;
      Ack   <= ack_nxt;
      Gated <= gated_nxt;
    end
  end

endmodule
